// File: rtl/aq_fdsu_ctrl_pkg.sv
// Shared types and defaults for the FDSU divide/sqrt sequencer.
package aq_fdsu_ctrl_pkg;

    localparam int unsigned ITER_DBL_DEF = 28;
    localparam int unsigned ITER_SGL_DEF = 13;
    localparam int unsigned CNT_W_DEF    = 5;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDnNeg = 3'd1,
        StEx1   = 3'd2,
        StEx2   = 3'd3,
        StEx3   = 3'd4,
        StEx4   = 3'd5
    } fdsu_state_e;

endpackage

// File: rtl/aq_fdsu_iter_cnt.sv
// SRT iteration counter: load at EX1 pipedown, count down through EX2, clear on flush.
module aq_fdsu_iter_cnt
    import aq_fdsu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             first
);

    logic [CNT_W-1:0] cnt_q;
    logic             first_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= load_val;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            // Saturate at zero so a stray decrement cannot wrap.
            if (dec && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign cnt   = cnt_q;
    assign last  = (cnt_q == CNT_W'(1));
    assign first = first_q;

endmodule

// File: rtl/aq_fdsu_double_ctrl.sv
// FDSU double-precision divide/sqrt pipeline sequencer (one op in flight).
// Optional FDSU_EARLY_FINISH_EN: special results bypass the SRT loop (EX1 -> EX3).
module aq_fdsu_double_ctrl
    import aq_fdsu_ctrl_pkg::*;
#(
    parameter int unsigned ITER_DBL = ITER_DBL_DEF,
    parameter int unsigned ITER_SGL = ITER_SGL_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             idu_fdsu_ex1_sel,
    input  logic             idu_fdsu_ex1_double,
    input  logic             fdsu_ex1_op0_denorm,
    input  logic             fdsu_ex1_special,
    input  logic             ctrl_xx_flush,
    input  logic             rtu_fdsu_wb_grant,
    output logic             fdsu_idu_busy,
    output logic             fdsu_ex1_save_op0,
    output logic             fdsu_save_op0_neg_expnt,
    output logic             ex1_pipedown,
    output logic             ex2_pipedown,
    output logic             ex3_pipedown,
    output logic             fdsu_srt_first,
    output logic [CNT_W-1:0] fdsu_srt_cnt,
    output logic             expnt_rst_clk_en,
    output logic             ex1_pipe_clk_en,
    output logic             ex2_pipe_clk_en,
    output logic             fdsu_rtu_wb_req
);

    fdsu_state_e state_q, state_d;

    logic             save_op0, save_neg, ex1_pd, ex2_pd, ex3_pd, srt_first, wb_req;
    logic             cnt_load, cnt_dec, cnt_last, cnt_first, early_fin, start;
    logic [CNT_W-1:0] cnt, cnt_init;

    assign cnt_init = idu_fdsu_ex1_double ? CNT_W'(ITER_DBL) : CNT_W'(ITER_SGL);

`ifdef FDSU_EARLY_FINISH_EN
    assign early_fin = fdsu_ex1_special;
`else
    assign early_fin = 1'b0;
`endif

    assign start = idu_fdsu_ex1_sel && (state_q == StIdle) && !ctrl_xx_flush;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        save_op0  = 1'b0;
        save_neg  = 1'b0;
        ex1_pd    = 1'b0;
        ex2_pd    = 1'b0;
        ex3_pd    = 1'b0;
        srt_first = 1'b0;
        wb_req    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (idu_fdsu_ex1_sel) begin
                    if (fdsu_ex1_op0_denorm) begin
                        save_op0 = 1'b1;
                        state_d  = StDnNeg;
                    end else begin
                        ex1_pd   = 1'b1;
                        cnt_load = !early_fin;
                        state_d  = early_fin ? StEx3 : StEx2;
                    end
                end
            end
            StDnNeg: begin
                save_neg = 1'b1;
                state_d  = StEx1;
            end
            StEx1: begin
                ex1_pd   = 1'b1;
                cnt_load = !early_fin;
                state_d  = early_fin ? StEx3 : StEx2;
            end
            StEx2: begin
                cnt_dec   = 1'b1;
                srt_first = cnt_first;
                if (cnt_last) begin
                    ex2_pd  = 1'b1;
                    state_d = StEx3;
                end
            end
            StEx3: begin
                ex3_pd  = 1'b1;
                state_d = StEx4;
            end
            StEx4: begin
                wb_req = 1'b1;
                if (rtu_fdsu_wb_grant) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush kills everything this cycle, including a coincident start or grant.
        if (ctrl_xx_flush) begin
            state_d   = StIdle;
            save_op0  = 1'b0;
            save_neg  = 1'b0;
            ex1_pd    = 1'b0;
            ex2_pd    = 1'b0;
            ex3_pd    = 1'b0;
            srt_first = 1'b0;
            wb_req    = 1'b0;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
        end
    end

    aq_fdsu_iter_cnt #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .clr      (ctrl_xx_flush),
        .load     (cnt_load),
        .load_val (cnt_init),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .last     (cnt_last),
        .first    (cnt_first)
    );

    // Reset is synchronous for state but masks every output in the same cycle.
    assign fdsu_idu_busy           = (state_q != StIdle) && !cpurst;
    assign fdsu_ex1_save_op0       = save_op0 && !cpurst;
    assign fdsu_save_op0_neg_expnt = save_neg && !cpurst;
    assign ex1_pipedown            = ex1_pd && !cpurst;
    assign ex2_pipedown            = ex2_pd && !cpurst;
    assign ex3_pipedown            = ex3_pd && !cpurst;
    assign fdsu_srt_first          = srt_first && !cpurst;
    assign fdsu_srt_cnt            = cpurst ? '0 : cnt;
    assign fdsu_rtu_wb_req         = wb_req && !cpurst;
    assign expnt_rst_clk_en        = (start || (state_q != StIdle)) && !ctrl_xx_flush && !cpurst;
    assign ex1_pipe_clk_en         = ex1_pipedown;
    assign ex2_pipe_clk_en         = ex2_pipedown;

    ex2_cnt_nonzero: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        (state_q == StEx2) |-> (cnt != '0));

endmodule

// File: tb/tb_aq_fdsu_double_ctrl.sv
// Scoreboard bench for aq_fdsu_double_ctrl; honours FDSU_EARLY_FINISH_EN when defined.
module tb_aq_fdsu_double_ctrl;

`ifdef FDSU_EARLY_FINISH_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, sel, dbl, dn, spc, flush, grant;
    logic       busy, save0, neg, ex1pd, ex2pd, ex3pd, first, ck_exp, ck_ex1, ck_ex2, wb;
    logic [4:0] srt_cnt;

    always #5 clk = ~clk;

    aq_fdsu_double_ctrl dut (
        .forever_cpuclk          (clk),
        .cpurst                  (rst),
        .idu_fdsu_ex1_sel        (sel),
        .idu_fdsu_ex1_double     (dbl),
        .fdsu_ex1_op0_denorm     (dn),
        .fdsu_ex1_special        (spc),
        .ctrl_xx_flush           (flush),
        .rtu_fdsu_wb_grant       (grant),
        .fdsu_idu_busy           (busy),
        .fdsu_ex1_save_op0       (save0),
        .fdsu_save_op0_neg_expnt (neg),
        .ex1_pipedown            (ex1pd),
        .ex2_pipedown            (ex2pd),
        .ex3_pipedown            (ex3pd),
        .fdsu_srt_first          (first),
        .fdsu_srt_cnt            (srt_cnt),
        .expnt_rst_clk_en        (ck_exp),
        .ex1_pipe_clk_en         (ck_ex1),
        .ex2_pipe_clk_en         (ck_ex2),
        .fdsu_rtu_wb_req         (wb)
    );

    // Event kinds: 0 save_op0, 1 neg_expnt, 2 ex1_pd, 3 srt_first, 4 ex2_pd, 5 ex3_pd, 6 wb_req rise
    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Drop every expected event at or after a kill cycle.
    function automatic void purge(input int from);
        ev_t keep[$];
        foreach (exp_q[i]) if (exp_q[i].cyc < from) keep.push_back(exp_q[i]);
        exp_q = keep;
    endfunction

    // Reference timeline of one op; returns the cycle wb_req first rises.
    function automatic int model_op(input int s, input bit d, input bit n, input bit sp);
        int o, it;
        o = s + (n ? 2 : 0);
        if (n) begin
            push(0, s, 0);
            push(1, s + 1, 0);
        end
        push(2, o, 0);
        if (EARLY && sp) begin
            push(5, o + 1, 0);
            push(6, o + 2, 0);
            return o + 2;
        end
        it = d ? 28 : 13;
        push(3, o + 1, it);
        push(4, o + it, 0);
        push(5, o + it + 1, 0);
        push(6, o + it + 2, 0);
        return o + it + 2;
    endfunction

    logic wb_prev = 1'b0;

    always @(negedge clk) begin
        logic [6:0] fired;
        ev_t        e;
        bit         ok;
        fired = {wb && !wb_prev, ex3pd, ex2pd, first, ex1pd, neg, save0};
        wb_prev = wb;
        for (int k = 0; k < 7; k++) begin
            if (fired[k]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d, want none", k, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == k) && (e.cyc == cyc) && (k != 3 || e.val == int'(srt_cnt))
                         && (k != 2 || ck_ex1) && (k != 4 || ck_ex2);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL event: got kind %0d cyc %0d cnt %0d ck1 %0b ck2 %0b, want kind %0d cyc %0d cnt %0d",
                                 k, cyc, srt_cnt, ck_ex1, ck_ex2, e.kind, e.cyc, e.val);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: flush at a random point, 1: reset at a random point, else run to writeback.
    task automatic run_op(input int mode, input bit d, input bit n, input bit sp);
        int s, wbc, f, h;
        bit done;
        s    = cyc;
        wbc  = model_op(s, d, n, sp);
        f    = (mode < 2) ? s + int'($urandom_range(0, wbc - s)) : -1;
        sel  = 1'b1;
        dbl  = d;
        dn   = n;
        spc  = sp;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (cyc == f) begin
                if (mode == 0) begin
                    flush = 1'b1;
                    grant = 1'($urandom % 2);
                end else begin
                    rst = 1'b1;
                end
                purge(cyc);
                #1;
                if (cyc == s) check("killed_start_clk_en", int'(ck_exp), 0);
                if (mode == 1) begin
                    check("rst_cnt", int'(srt_cnt), 0);
                    check("rst_busy", int'(busy), 0);
                    check("rst_wb_req", int'(wb), 0);
                end
                tick();
                flush = 1'b0;
                rst   = 1'b0;
                grant = 1'b0;
                sel   = 1'b0;
                #1;
                check("idle_after_kill", int'(busy), 0);
                done = 1'b1;
            end else if (cyc == wbc) begin
                h = int'($urandom_range(0, 5));
                #1;
                check("wb_req", int'(wb), 1);
                for (int j = 0; j < h; j++) begin
                    sel = 1'($urandom % 2);
                    tick();
                    check("wb_hold", int'(wb), 1);
                end
                grant = 1'b1;
                tick();
                grant = 1'b0;
                sel   = 1'b0;
                #1;
                check("idle_after_wb", int'(busy), 0);
                done = 1'b1;
            end else begin
                #1;
                if (cyc == s) check("start_clk_en", int'(ck_exp), 1);
                tick();
                sel = 1'b0;
            end
        end
        if (!done) check("op_timeout", 0, 1);
    endtask

    initial begin
        rst   = 1'b1;
        sel   = 1'b1;
        dbl   = 1'b0;
        dn    = 1'b0;
        spc   = 1'b0;
        flush = 1'b0;
        grant = 1'b0;
        tick();
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_ex1_pd", int'(ex1pd), 0);
        check("reset_cnt", int'(srt_cnt), 0);
        check("reset_clk_en", int'(ck_exp), 0);
        tick();
        rst = 1'b0;
        sel = 1'b0;
        tick();
        check("post_reset_busy", int'(busy), 0);

        run_op(2, 1'b1, 1'b0, 1'b0);
        run_op(2, 1'b0, 1'b1, 1'b0);
        run_op(2, 1'b1, 1'b0, 1'b1);
        run_op(2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 36; i++) begin
            run_op(int'($urandom_range(0, 5)), 1'($urandom % 2), 1'($urandom % 2),
                   ($urandom % 4) == 0);
        end
        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
